// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl: button-driven date/time editor with shadow registers, one-cycle commit strobe and idle timeout.
module watch_set_ctrl #(
  parameter int TIMEOUT_SEC = 30,
  parameter int YEAR_MIN    = 1,
  parameter int YEAR_MAX    = 4095
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clk1sec_i,
  input  logic        btn_mode_i,
  input  logic        btn_up_i,
  input  logic        btn_down_i,
  input  logic        btn_ok_i,
  input  logic [11:0] year_i,
  input  logic [7:0]  month_i,
  input  logic [7:0]  day_i,
  input  logic [7:0]  hour_i,
  input  logic [7:0]  minute_i,
  input  logic [7:0]  second_i,
  output logic        set_time_o,
  output logic [51:0] bin_time_o,
  output logic        edit_active_o,
  output logic [2:0]  edit_field_o,
  output logic        blink_o
);
  typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_e;
  localparam logic [11:0] YMIN = 12'(YEAR_MIN);
  localparam logic [11:0] YMAX = 12'(YEAR_MAX);
  localparam logic [7:0]  TO   = 8'(TIMEOUT_SEC);

  function automatic logic [7:0] dmax_f(input logic [7:0] m, input logic [11:0] y);
    logic leap;
    leap = (y[1:0] == 2'd0 && (y % 12'd100) != 12'd0) || (y % 12'd400) == 12'd0;
    return (m == 8'd2) ? (leap ? 8'd29 : 8'd28) :
           (m == 8'd4 || m == 8'd6 || m == 8'd9 || m == 8'd11) ? 8'd30 : 8'd31;
  endfunction

  function automatic logic [7:0] step_f(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi, input logic up);
    return up ? ((v >= hi) ? lo : v + 8'd1) : ((v <= lo) ? hi : v - 8'd1);
  endfunction

  state_e      state_q, state_d;
  logic [11:0] yr_q, yr_d;
  logic [7:0]  mo_q, mo_d, dy_q, dy_d, hr_q, hr_d, mi_q, mi_d, se_q, se_d, cnt_q, cnt_d;
  logic [2:0]  field_q, field_d;
  logic        blink_q, blink_d;
  logic        step, up;
  logic [7:0]  dm_new;

  // ok and mode outrank the value buttons, so a step only happens when neither is pressed
  assign step = !btn_ok_i && !btn_mode_i && (btn_up_i || btn_down_i);
  assign up   = btn_up_i;

  always_comb begin
    state_d = state_q;
    yr_d    = yr_q;
    mo_d    = mo_q;
    dy_d    = dy_q;
    hr_d    = hr_q;
    mi_d    = mi_q;
    se_d    = se_q;
    field_d = field_q;
    cnt_d   = cnt_q;
    dm_new  = 8'd0;
    case (state_q)
      IDLE: if (btn_mode_i) begin
        {yr_d, mo_d, dy_d, hr_d, mi_d, se_d} = {year_i, month_i, day_i, hour_i, minute_i, second_i};
        field_d = 3'd0;
        cnt_d   = 8'd0;
        state_d = EDIT;
      end
      EDIT: if (btn_ok_i) begin
        state_d = COMMIT;
        cnt_d   = 8'd0;
      end else if (btn_mode_i) begin
        field_d = (field_q >= 3'd5) ? 3'd0 : field_q + 3'd1;
        cnt_d   = 8'd0;
      end else if (step) begin
        cnt_d = 8'd0;
        case (field_q)
          3'd0:    yr_d = up ? ((yr_q >= YMAX) ? YMIN : yr_q + 12'd1) : ((yr_q <= YMIN) ? YMAX : yr_q - 12'd1);
          3'd1:    mo_d = step_f(mo_q, 8'd1, 8'd12, up);
          3'd2:    dy_d = step_f(dy_q, 8'd1, dmax_f(mo_q, yr_q), up);
          3'd3:    hr_d = step_f(hr_q, 8'd0, 8'd23, up);
          3'd4:    mi_d = step_f(mi_q, 8'd0, 8'd59, up);
          default: se_d = step_f(se_q, 8'd0, 8'd59, up);
        endcase
        dm_new = dmax_f(mo_d, yr_d);
        if (field_q <= 3'd1 && dy_d > dm_new) dy_d = dm_new;
      end else if (clk1sec_i) begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_d >= TO) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    blink_d = (state_d == EDIT) ? blink_q ^ (clk1sec_i && state_q == EDIT) : 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      {yr_q, mo_q, dy_q, hr_q, mi_q, se_q} <= '0;
      field_q <= 3'd0;
      cnt_q   <= 8'd0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      {yr_q, mo_q, dy_q, hr_q, mi_q, se_q} <= {yr_d, mo_d, dy_d, hr_d, mi_d, se_d};
      field_q <= field_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

  assign set_time_o    = state_q == COMMIT;
  assign edit_active_o = state_q != IDLE;
  assign edit_field_o  = field_q;
  assign blink_o       = blink_q;
  assign bin_time_o    = {yr_q, mo_q, dy_q, hr_q, mi_q, se_q};
endmodule

// File: tb/tb_watch_set_ctrl.sv
// tb_watch_set_ctrl: directed checks of the watch setting controller with a 3-second timeout.
module tb_watch_set_ctrl;
  logic        clk = 0, rst_n = 0, sec = 0, b_mode = 0, b_up = 0, b_down = 0, b_ok = 0;
  logic [11:0] year = 0;
  logic [7:0]  month = 0, day = 0, hour = 0, minute = 0, second = 0;
  logic        set_time, edit_active, blink;
  logic [51:0] bin_time;
  logic [2:0]  edit_field;
  int checks = 0, failures = 0, stp = 0;

  watch_set_ctrl #(.TIMEOUT_SEC(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clk1sec_i(sec),
    .btn_mode_i(b_mode), .btn_up_i(b_up), .btn_down_i(b_down), .btn_ok_i(b_ok),
    .year_i(year), .month_i(month), .day_i(day), .hour_i(hour), .minute_i(minute), .second_i(second),
    .set_time_o(set_time), .bin_time_o(bin_time), .edit_active_o(edit_active),
    .edit_field_o(edit_field), .blink_o(blink)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (set_time) stp++;

  function automatic logic [51:0] pk(input int y, mo, d, h, mi, s);
    return {12'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic live(input int y, mo, d, h, mi, s);
    {year, month, day, hour, minute, second} = pk(y, mo, d, h, mi, s);
  endtask

  task automatic mode(input int n);
    for (int i = 0; i < n; i++) begin b_mode = 1; tick(); b_mode = 0; end
  endtask

  task automatic upn(input int n);
    for (int i = 0; i < n; i++) begin b_up = 1; tick(); b_up = 0; end
  endtask

  task automatic down();
    b_down = 1; tick(); b_down = 0;
  endtask

  task automatic ok();
    b_ok = 1; tick(); b_ok = 0;
  endtask

  task automatic pulse_sec();
    sec = 1; tick(); sec = 0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_set_time", set_time, 0);
    chk("rst_edit_active", edit_active, 0);
    chk("rst_field_blink", {edit_field, blink}, 0);
    chk("rst_bin_time", bin_time, 0);
    rst_n = 1;
    tick();
    live(2021, 5, 30, 18, 32, 7);
    ok(); upn(1); down(); tick();
    chk("idle_ignores_buttons", {set_time, edit_active, bin_time}, 0);
    chk("idle_no_strobe", stp, 0);
    mode(1);
    chk("capture_active", edit_active, 1);
    chk("capture_bin", bin_time, pk(2021, 5, 30, 18, 32, 7));
    mode(3);
    chk("field_hour", edit_field, 3);
    upn(2);
    chk("hour_plus2", bin_time, pk(2021, 5, 30, 20, 32, 7));
    ok();
    chk("commit_strobe", set_time, 1);
    chk("commit_bin", bin_time, pk(2021, 5, 30, 20, 32, 7));
    tick();
    chk("commit_done", {set_time, edit_active}, 0);
    chk("one_pulse", stp, 1);
    chk("bin_stable", bin_time, pk(2021, 5, 30, 20, 32, 7));

    live(2020, 2, 29, 10, 0, 0);
    mode(1); upn(1);
    chk("leap_clamp", bin_time, pk(2021, 2, 28, 10, 0, 0));
    mode(1); down(); down();
    chk("month_1_to_12", bin_time, pk(2021, 12, 28, 10, 0, 0));
    upn(1);
    chk("month_12_to_1", bin_time, pk(2021, 1, 28, 10, 0, 0));
    mode(3); down();
    chk("minute_0_to_59", bin_time, pk(2021, 1, 28, 10, 59, 0));
    mode(1); down(); mode(1);
    chk("field_wrap", edit_field, 0);
    chk("second_0_to_59", bin_time, pk(2021, 1, 28, 10, 59, 59));
    ok(); tick();
    chk("second_pulse", stp, 2);

    live(1, 3, 31, 0, 0, 0);
    mode(1); down();
    chk("year_1_to_4095", bin_time, pk(4095, 3, 31, 0, 0, 0));
    mode(1); down();
    chk("month_clamp_nonleap", bin_time, pk(4095, 2, 28, 0, 0, 0));
    b_ok = 1; b_up = 1; tick(); b_ok = 0; b_up = 0;
    chk("ok_beats_up", set_time, 1);
    chk("ok_up_shadow", bin_time, pk(4095, 2, 28, 0, 0, 0));
    tick();
    chk("third_pulse", stp, 3);

    live(2000, 1, 1, 0, 0, 0);
    mode(1);
    pulse_sec();
    chk("blink_1", blink, 1);
    pulse_sec();
    chk("blink_0", {edit_active, blink}, 2'b10);
    b_up = 1; sec = 1; tick(); b_up = 0; sec = 0;
    chk("btn_with_sec", {edit_active, blink}, 2'b11);
    chk("btn_with_sec_year", bin_time, pk(2001, 1, 1, 0, 0, 0));
    pulse_sec(); pulse_sec();
    chk("restart_still_edit", edit_active, 1);
    pulse_sec();
    chk("timeout_idle", {edit_active, blink, set_time}, 0);
    chk("timeout_no_strobe", stp, 3);

    mode(1); upn(1);
    chk("pre_reset_edit", edit_active, 1);
    #2 rst_n = 0;
    #1;
    chk("async_reset_outputs", {set_time, edit_active, edit_field, blink}, 0);
    chk("async_reset_bin", bin_time, 0);
    tick();
    rst_n = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("post_reset_no_strobe", stp, 3);
    chk("post_reset_idle", {edit_active, bin_time}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/watch_set_ctrl.md
WATCH_SET_CTRL -- requirements
Module: watch_set_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_SEC, default 30: idle seconds in edit before auto-abort (range 1..255).
REQ-002 SHALL have parameter YEAR_MIN, default 1: lowest editable year.
REQ-003 SHALL have parameter YEAR_MAX, default 4095: highest editable year.
REQ-004 SHALL have one clock and asynchronous active-low reset: clk  in  1  system clock, rising edge.
REQ-005 SHALL have rst  in  1  asynchronous reset, active-low.
REQ-006 SHALL have clk1sec  in  1  one-cycle pulse per second.
REQ-007 SHALL have btn_mode, btn_up, btn_down, btn_ok  in  1 each  debounced single-cycle button pulses.
REQ-008 SHALL have year  in  12, and month, day, hour, minute, second  in  8 each: live time from the watch counter.
REQ-009 SHALL have set_time  out  1  one-cycle load strobe to the watch counter.
REQ-010 SHALL have bin_time  out  52  {year[11:0], month, day, hour, minute, second} load value.
REQ-011 SHALL have edit_active  out  1, edit_field  out  3 (0 year, 1 month, 2 day, 3 hour, 4 minute, 5 second), and blink  out  1.

Function
REQ-012 SHALL implement FSM states IDLE, EDIT, COMMIT.
REQ-013 SHALL, in IDLE on btn_mode, copy the live inputs into shadow registers, set edit_field=0 and the timeout count to 0, and enter EDIT on the next cycle.
REQ-014 SHALL ignore btn_up, btn_down and btn_ok in IDLE.
REQ-015 SHALL act on at most one button per cycle in EDIT, with priority btn_ok > btn_mode > btn_up > btn_down.
REQ-016 SHALL, on btn_mode in EDIT, advance edit_field 0->1->...->5->0.
REQ-017 SHALL, on btn_up, increment the selected shadow field with wrap: year YEAR_MAX->YEAR_MIN; month 12->1; day dmax->1; hour 23->0; minute and second 59->0.
REQ-018 SHALL, on btn_down, decrement the selected shadow field with wrap: year YEAR_MIN->YEAR_MAX; month 1->12; day 1->dmax; hour 0->23; minute and second 0->59.
REQ-019 SHALL compute dmax from the shadow month and year: 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; 28+leap for month 2.
REQ-020 SHALL define leap as (year%4==0 and year%100!=0) or year%400==0.
REQ-021 SHALL, in the same cycle as any year or month change, clamp the shadow day to the new dmax when the day exceeds it.
REQ-022 SHALL, on btn_ok in EDIT, enter COMMIT.
REQ-023 SHALL, in COMMIT, assert set_time for exactly one cycle and then return to IDLE.
REQ-024 SHALL drive bin_time from the shadow registers at all times, so it is stable during and after the set_time cycle.
REQ-025 SHALL, in EDIT, increment the timeout count on clk1sec and reset it to 0 on any acted button.
REQ-026 SHALL, when a button and clk1sec coincide, let the button win and leave the count at 0.
REQ-027 SHALL, when the count reaches TIMEOUT_SEC, return to IDLE without asserting set_time (abort).
REQ-028 SHALL assert edit_active in EDIT and COMMIT, and deassert it in IDLE.
REQ-029 SHALL toggle blink on each clk1sec in EDIT, and hold blink at 0 outside EDIT.
REQ-030 SHALL hold the shadow registers unchanged outside EDIT, except when capturing on IDLE btn_mode.

Reset
REQ-031 SHALL, on rst low at any time including mid-edit, immediately force state IDLE, set_time 0, edit_active 0, edit_field 0, blink 0, timeout count 0, all shadow fields 0 and therefore bin_time 0.
REQ-032 SHALL issue no set_time after reset release until a full EDIT->COMMIT sequence completes.

Verification
REQ-033 SHALL pass: live 2021-05-30 18:32:07, btn_mode, 3x btn_mode, 2x btn_up, btn_ok -> one set_time pulse with bin_time {2021,5,30,20,32,7}.
REQ-034 SHALL pass: shadow 2020-02-29, field year, btn_up -> year 2021, day clamped to 28 in the same cycle.
REQ-035 SHALL pass: field minute=0 with btn_down -> 59; field year=1 with btn_down -> 4095; month 12 with btn_up -> 1.
REQ-036 SHALL pass: with TIMEOUT_SEC=3, EDIT and no buttons for 3 clk1sec -> IDLE, no set_time; a button after 2 clk1sec restarts the count.
REQ-037 SHALL pass: btn_ok and btn_up in the same cycle -> COMMIT taken, shadow unchanged.
REQ-038 SHALL pass: rst low during EDIT -> all outputs at reset values within the reset assertion; no set_time after release.
